cmos_spi_cmd_master: RTL
========================

# cmos_spi_cmd_master

Drains 16-bit sensor register commands from the command FIFO and serialises each one to the CMOS image sensor over a 4-wire SPI bus (mode 0, MSB first). It sits directly upstream of the frame-request generator. Its `spi_idle_fd` pulse, combined with `command_fifo_empty`, tells that stage the last configuration write has completed and a frame may be requested. Read commands return the sensor's 8-bit register value on `rd_data`.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period; legal range 1..255.
- `CS_SETUP`, 2: clk cycles from CS_n fall to the first SCLK rise region (SETUP state length); legal range 1..255.
- `CS_HOLD`, 2: clk cycles from the end of the last bit to CS_n rise; legal range 1..255.
- `CS_GAP`, 4: minimum clk cycles CS_n stays high between transactions; legal range 1..255.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `command_fifo_dout`  in  16  FIFO read data, standard (non-FWFT) FIFO, valid 1 cycle after `command_fifo_rd_en`. [15] = 1 write / 0 read, [14:8] = register address, [7:0] = write data.
- `command_fifo_empty`  in  1  FIFO empty flag.
- `command_fifo_rd_en`  out  1  single-cycle pop strobe.
- `spi_sclk`  out  1  SPI clock; idles low.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_mosi`  out  1  serial data to the sensor.
- `spi_miso`  in  1  serial data from the sensor; already synchronised upstream.
- `rd_data`  out  8  last read result; held until the next read completes.
- `rd_data_valid`  out  1  one-cycle pulse when `rd_data` updates.
- `spi_busy`  out  1  high in every state except IDLE.
- `spi_idle_fd`  out  1  one-cycle pulse each time a transaction finishes and the block returns to IDLE.

## Operation
- The FSM has the states IDLE, FETCH, LATCH, SETUP, SHIFT, HOLD, GAP. All outputs are registered.
- IDLE: if `command_fifo_empty` = 0, go to FETCH. Otherwise stay in IDLE.
- FETCH: assert `command_fifo_rd_en` for exactly this cycle, then go to LATCH.
- LATCH: capture `command_fifo_dout` into a 16-bit shift register and clear the 8-bit receive register. Go to SETUP.
- SETUP: drive `spi_cs_n` = 0 and `spi_mosi` = bit 15. Stay for CS_SETUP cycles, then go to SHIFT.
- SHIFT: 16 bits, each lasting 2·CLK_DIV cycles.
  - SCLK is low for the first CLK_DIV cycles of a bit and high for the second CLK_DIV cycles.
  - On each SCLK rising edge, shift `spi_miso` into the receive register.
  - On each SCLK falling edge, `spi_mosi` advances to the next bit. The bit counter is 5 bits, 0..15.
  - After bit 0's high phase, SCLK returns low and the FSM goes to HOLD.
- HOLD: `spi_cs_n` stays low for CS_HOLD cycles, then goes to GAP.
- GAP: `spi_cs_n` = 1 and `spi_mosi` = 0 for CS_GAP cycles, then go to IDLE.
- `spi_idle_fd` pulses in the first IDLE cycle after GAP.
- If the command was a read (bit 15 = 0), `rd_data` takes the last 8 sampled MISO bits and `rd_data_valid` pulses in that same cycle. A write leaves `rd_data` unchanged and gives no valid pulse.
- The MOSI low byte is shifted out as stored, even for reads.
- Phase counters are 8 bits and count from 0 up to the parameter value minus 1.

## Timing
- Reset values: `command_fifo_rd_en` 0, `spi_sclk` 0, `spi_cs_n` 1, `spi_mosi` 0, `rd_data` 8'h00, `rd_data_valid` 0, `spi_busy` 0, `spi_idle_fd` 0. The FSM resets to IDLE.
- Start latency: the first IDLE cycle seeing not-empty leads to `rd_en` on the next cycle. `spi_cs_n` falls 2 cycles after `rd_en`.
- CS_n low time = CS_SETUP + 32·CLK_DIV + CS_HOLD cycles; with defaults this is 132.
- Back-to-back commands: period = 1 (IDLE) + 1 + 1 + CS_SETUP + 32·CLK_DIV + CS_HOLD + CS_GAP; with defaults this is 139 cycles. `spi_idle_fd` pulses once per command, including between back-to-back commands.
- The FIFO is popped exactly once per transaction and never while empty. The empty flag is sampled only in IDLE.
- `rst` mid-transaction takes effect on the next clk edge: CS_n goes high and SCLK low immediately. The in-flight command is discarded, not retried, and neither `spi_idle_fd` nor `rd_data_valid` pulses.
- With CLK_DIV = 1, SCLK toggles every cycle and MISO is sampled in the high cycle of each bit.

## Test plan
- Reset then idle with empty FIFO: all outputs hold their reset values for 50 cycles, and `command_fifo_rd_en` never asserts.
- Single write 16'hA55A with defaults: MOSI bits 1010_0101_0101_1010 are stable on every SCLK rise; there are exactly 16 SCLK pulses; CS_n is low for 132 cycles; `spi_idle_fd` pulses once; there is no `rd_data_valid`.
- Read 16'h3F00 while the MISO model returns 8'hC3 on the last 8 bits: `rd_data` = 8'hC3 with one `rd_data_valid` pulse, in the same cycle as `spi_idle_fd`.
- Three commands queued: 3 `rd_en` pulses spaced 139 cycles apart, 3 `spi_idle_fd` pulses, and CS_n high for at least 4 cycles between transactions. `command_fifo_empty` = 1 at the third `spi_idle_fd`.
- Reset asserted at bit 7 of SHIFT: CS_n = 1 and SCLK = 0 on the next cycle, with no `spi_idle_fd`. A subsequently queued command then runs normally.
- CLK_DIV = 1, CS_GAP = 1: SCLK period is 2 cycles and the back-to-back period is 1+1+1+2+32+2+1 = 40 cycles.

Source files
------------

// File: rtl/cmos_spi_cmd_master.sv
// cmos_spi_cmd_master
// Pops 16-bit register commands from a standard (non-FWFT) FIFO and shifts
// each one out to the CMOS sensor over SPI mode 0, MSB first. Read commands
// (bit 15 = 0) return the last 8 sampled MISO bits on rd_data. A one-cycle
// spi_idle_fd pulse marks the return to IDLE after every transaction.
// Every output is driven straight from a flop.

module cmos_spi_cmd_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] command_fifo_dout,
  input  logic        command_fifo_empty,
  output logic        command_fifo_rd_en,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [7:0]  rd_data,
  output logic        rd_data_valid,
  output logic        spi_busy,
  output logic        spi_idle_fd
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SETUP = 3'd3,
    ST_SHIFT = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  // Terminal values of the 8-bit phase counter in each timed state.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  // State and datapath registers
  state_t      state_r;
  logic [7:0]  phase_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic [7:0]  rx_r;
  logic        cmd_wr_r;

  // Output registers; sclk_r also serves as the low/high half-bit flag.
  logic        rd_en_r;
  logic        sclk_r;
  logic        cs_n_r;
  logic        mosi_r;
  logic [7:0]  rd_data_r;
  logic        rd_valid_r;
  logic        busy_r;
  logic        idle_fd_r;

  // Next-state values
  state_t      state_s;
  logic [7:0]  phase_cnt_s;
  logic [4:0]  bit_cnt_s;
  logic [15:0] shift_s;
  logic [7:0]  rx_s;
  logic        cmd_wr_s;
  logic        sclk_s;
  logic        rd_en_s;
  logic        cs_n_s;
  logic        mosi_s;
  logic [7:0]  rd_data_s;
  logic        rd_valid_s;
  logic        busy_s;
  logic        idle_fd_s;
  logic        in_frame_s;
  logic        done_s;

  // Next-state, counter and shift-register logic for the transaction FSM.
  always_comb begin
    state_s     = state_r;
    phase_cnt_s = phase_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    rx_s        = rx_r;
    cmd_wr_s    = cmd_wr_r;
    sclk_s      = sclk_r;
    case (state_r)
      ST_IDLE: begin
        if (!command_fifo_empty) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        shift_s     = command_fifo_dout;
        cmd_wr_s    = command_fifo_dout[15];
        rx_s        = 8'h00;
        phase_cnt_s = 8'd0;
        state_s     = ST_SETUP;
      end
      ST_SETUP: begin
        if (phase_cnt_r == SETUP_LAST) begin
          phase_cnt_s = 8'd0;
          bit_cnt_s   = 5'd15;
          sclk_s      = 1'b0;
          state_s     = ST_SHIFT;
        end else begin
          phase_cnt_s = phase_cnt_r + 8'd1;
        end
      end
      ST_SHIFT: begin
        // Sample MISO once per bit, in the first cycle SCLK is high.
        if (sclk_r && (phase_cnt_r == 8'd0)) begin
          rx_s = {rx_r[6:0], spi_miso};
        end else begin
          rx_s = rx_r;
        end
        if (phase_cnt_r == DIV_LAST) begin
          phase_cnt_s = 8'd0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            // Falling edge: advance MOSI, or finish after bit 0.
            sclk_s = 1'b0;
            if (bit_cnt_r == 5'd0) begin
              state_s = ST_HOLD;
            end else begin
              bit_cnt_s = bit_cnt_r - 5'd1;
              shift_s   = {shift_r[14:0], 1'b0};
            end
          end
        end else begin
          phase_cnt_s = phase_cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (phase_cnt_r == HOLD_LAST) begin
          phase_cnt_s = 8'd0;
          state_s     = ST_GAP;
        end else begin
          phase_cnt_s = phase_cnt_r + 8'd1;
        end
      end
      ST_GAP: begin
        if (phase_cnt_r == GAP_LAST) begin
          phase_cnt_s = 8'd0;
          state_s     = ST_IDLE;
        end else begin
          phase_cnt_s = phase_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        phase_cnt_s = 8'd0;
        sclk_s      = 1'b0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so that
  // every pin is registered and lines up with the state it belongs to.
  always_comb begin
    in_frame_s = (state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_HOLD);
    done_s     = (state_r == ST_GAP) && (state_s == ST_IDLE);
    rd_en_s    = (state_s == ST_FETCH);
    busy_s     = (state_s != ST_IDLE);
    cs_n_s     = !in_frame_s;
    idle_fd_s  = done_s;
    rd_valid_s = done_s && !cmd_wr_r;
    if (in_frame_s) begin
      mosi_s = shift_s[15];
    end else begin
      mosi_s = 1'b0;
    end
    if (done_s && !cmd_wr_r) begin
      rd_data_s = rx_r;
    end else begin
      rd_data_s = rd_data_r;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= 8'd0;
      bit_cnt_r   <= 5'd0;
      shift_r     <= 16'h0000;
      rx_r        <= 8'h00;
      cmd_wr_r    <= 1'b0;
      rd_en_r     <= 1'b0;
      sclk_r      <= 1'b0;
      cs_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      rd_data_r   <= 8'h00;
      rd_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      idle_fd_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_cnt_r <= phase_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      rx_r        <= rx_s;
      cmd_wr_r    <= cmd_wr_s;
      rd_en_r     <= rd_en_s;
      sclk_r      <= sclk_s;
      cs_n_r      <= cs_n_s;
      mosi_r      <= mosi_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
      busy_r      <= busy_s;
      idle_fd_r   <= idle_fd_s;
    end
  end

  assign command_fifo_rd_en = rd_en_r;
  assign spi_sclk           = sclk_r;
  assign spi_cs_n           = cs_n_r;
  assign spi_mosi           = mosi_r;
  assign rd_data            = rd_data_r;
  assign rd_data_valid      = rd_valid_r;
  assign spi_busy           = busy_r;
  assign spi_idle_fd        = idle_fd_r;

endmodule
